fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch path: owns the fetch PC, issues requests on the instruction bus and buffers returned instructions in a small queue for the decode stage.
- Handles redirects (branch/exception flush) while a bus request is in flight by holding the old request until it completes and discarding its data.
- Sits between the PC-select logic and decode; the bus port drives the shared instruction bus.

Parameters:
- RESET_PC, 64'h8000_0000, PC loaded at reset.
- QDEPTH, 2, fetch-queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  redirect request from execute/commit
- redirect_pc  in  64  new PC, valid when flush=1
- ireq  out  ibus_req_t  instruction-bus request; valid and addr driven
- iresp  in  ibus_resp_t  bus response; data_ok and data used
- dataF  out  fetch_data_t  queue head: {instr.pc, instr.raw_instr}, valid
- readyD  in  1  decode accepts dataF this cycle

Behaviour:
- Reset, synchronous on reset=1 at a rising edge:
  - pc_q=RESET_PC, state=IDLE, queue empty.
  - ireq.valid=0, ireq.addr=RESET_PC.
  - dataF.valid=0, dataF.instr=0.
- Queue: circular buffer with head/tail pointers of log2(QDEPTH) bits and a count of log2(QDEPTH)+1 bits.
  - Wrap-around is natural overflow of the pointers.
  - dataF.valid = count!=0; dataF.instr = entry at head. Outputs come straight from registers; no combinational path from iresp.
  - Pop when dataF.valid && readyD. Push and pop may occur in the same cycle.
- ireq is driven from registers only:
  - ireq.valid = (state==REQ || state==DROP).
  - ireq.addr = the latched request address, held stable until data_ok.
- States:
  - IDLE:
    - If flush: pc_q<=redirect_pc, stay IDLE.
    - Else if count_next < QDEPTH: latch req_addr<=pc_q, go REQ. count_next is the post-pop count this cycle.
  - REQ, data_ok=1, flush=0:
    - Push {req_addr, data[31:0]} and set pc_q<=req_addr+4 (64-bit wrap).
    - If the post-push/pop count < QDEPTH: latch req_addr<=req_addr+4 and stay in REQ, giving back-to-back requests. Otherwise go IDLE.
  - REQ, data_ok=0, flush=1: save pc_q<=redirect_pc, go DROP; ireq is unchanged.
  - REQ, data_ok=1, flush=1: discard data, pc_q<=redirect_pc, go IDLE.
  - REQ, data_ok=0, flush=0: hold.
  - DROP, data_ok=1: discard data, go IDLE.
  - DROP, flush=1: overwrite pc_q<=redirect_pc. If data_ok is also 1, go IDLE.
- flush in any state: queue cleared (count<=0, head<=tail) at the next edge. A same-cycle push or pop is ignored, and flush has priority over push.
- Latency:
  - Redirect to first request: 1 cycle (flush edge → IDLE → REQ).
  - Bus response to dataF.valid: 1 cycle.
- reset asserted mid-request: state returns to IDLE and ireq.valid drops. The team's bus is reset in the same cycle, so no drop tracking is needed across reset.
- Never pushes when the queue is full, by construction. Assertion to include: push && count==QDEPTH never occurs.

Optional Feature:
- Macro FETCH_CTRL_PERF_EN.
- When defined, adds outputs perf_fetched (32) and perf_dropped (32):
  - perf_fetched increments per push.
  - perf_dropped increments per discarded response, from DROP or from REQ with flush+data_ok.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- pipeline package gains fetch_state_t enum {IDLE, REQ, DROP} and localparam INSTR_BYTES=4.
- common package already supplies word_t, ibus_req_t and ibus_resp_t.
- One sub-module, fetch_queue: the parameterised circular FIFO with push, pop, clear, full, empty and head ports.
- fetch_ctrl instantiates fetch_queue and holds the FSM and PC.

Test Plan:
- Reset, then a bus that returns data_ok one cycle after valid, readyD=1 → addresses 8000_0000, 8000_0004, 8000_0008 issued; dataF.valid one cycle after each data_ok, carrying the matching pc and data.
- readyD=0 for 10 cycles → exactly 2 pushes; ireq.valid then 0 and state IDLE; raising readyD resumes fetch from 8000_0008.
- flush with redirect_pc=8000_1000 while REQ has been waiting 3 cycles → ireq.addr stays 8000_0004 until data_ok; that data is not pushed; next request is 8000_1000.
- flush coincident with data_ok → response discarded, queue empty next cycle, next request 8000_1000.
- Two flushes during DROP (8000_1000 then 8000_2000) → next request is 8000_2000; with FETCH_CTRL_PERF_EN, perf_dropped=1.
- reset asserted while in REQ → next cycle ireq.valid=0, dataF.valid=0, then fetch restarts at 8000_0000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module  : fetch_ctrl_pkg
// Purpose : Shared types for the instruction-fetch slice. These are the bus
//           request/response structs, the fetch-queue entry, the decode-facing
//           output bundle and the fetch FSM state encoding.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

  typedef logic [63:0] word_t;
  typedef logic [31:0] instr_t;

  // Instruction-bus request: address is held stable while valid until data_ok.
  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic   data_ok;
    instr_t data;
  } ibus_resp_t;

  typedef struct packed {
    word_t  pc;
    instr_t raw_instr;
  } fetch_instr_t;

  typedef struct packed {
    logic         valid;
    fetch_instr_t instr;
  } fetch_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module  : fetch_queue
// Purpose : Circular FIFO that buffers fetched instructions for decode.
//           Pointers wrap by natural overflow (QDEPTH is a power of two).
//           Clear has priority over a same-cycle push/pop.
// Ports   : clk, reset     - clock, synchronous active-high reset
//           push_i/data    - write one entry at tail
//           pop_i          - drop the head entry (ignored when empty)
//           clear_i        - empty the queue (head <= tail)
//           full_o/empty_o - occupancy flags
//           count_o        - occupancy, log2(QDEPTH)+1 bits
//           head_o         - entry at head, straight from storage
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  fetch_instr_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(QDEPTH):0]  count_o,
  output fetch_instr_t             head_o
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  fetch_instr_t    mem_q [QDEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic            do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // Zeroed so the decode-facing instr field reads 0 out of reset.
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      count_q <= '0;
      head_q  <= tail_q;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (do_pop) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module  : fetch_ctrl
// Purpose : Instruction-fetch sequencer. It owns the fetch PC, issues requests
//           on the instruction bus and buffers responses in fetch_queue for
//           decode. A redirect arriving while a request is outstanding keeps
//           the old request on the bus until it completes, then discards it.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           flush           - redirect request; redirect_pc is the new PC
//           ireq            - bus request (valid/addr), registered
//           iresp           - bus response (data_ok/data)
//           dataF           - queue head for decode, registered
//           readyD          - decode consumes dataF this cycle
//           perf_fetched    - (FETCH_CTRL_PERF_EN) pushed-instruction count
//           perf_dropped    - (FETCH_CTRL_PERF_EN) discarded-response count
// Options : `define FETCH_CTRL_PERF_EN to add the two performance counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter word_t       RESET_PC = 64'h8000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  word_t       redirect_pc,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output fetch_data_t dataF,
  input  logic        readyD
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  fetch_state_t  state_q;
  word_t         pc_q;
  word_t         req_addr_q;

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  fetch_instr_t  head;

  logic          push;
  logic          pop;
  logic          drop_rsp;
  logic [CW-1:0] count_pop_d;
  logic [CW-1:0] count_push_d;
  word_t         next_addr;
  fetch_instr_t  push_data;

  // Flush clears the queue, so a same-cycle pop is meaningless and suppressed.
  assign pop          = !empty && readyD && !flush;
  assign push         = (state_q == REQ) && iresp.data_ok && !flush;
  assign drop_rsp     = iresp.data_ok &&
                        (((state_q == REQ) && flush) || (state_q == DROP));
  assign count_pop_d  = count - CW'(pop);
  assign count_push_d = count + CW'(1'b1) - CW'(pop);
  assign next_addr    = req_addr_q + word_t'(INSTR_BYTES);
  assign push_data    = '{pc: req_addr_q, raw_instr: iresp.data};

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .clear_i     (flush),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count),
    .head_o      (head)
  );

  // Fetch FSM. pc_q is the next address to fetch and req_addr_q is the address
  // currently presented on the bus, which must not move until data_ok.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            pc_q <= redirect_pc;
          end else if (count_pop_d < DEPTH_C) begin
            req_addr_q <= pc_q;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (iresp.data_ok) begin
            if (flush) begin
              pc_q    <= redirect_pc;
              state_q <= IDLE;
            end else begin
              pc_q <= next_addr;
              // Room left after this push: issue the next fetch back-to-back.
              if (count_push_d < DEPTH_C) begin
                req_addr_q <= next_addr;
              end else begin
                state_q <= IDLE;
              end
            end
          end else if (flush) begin
            pc_q    <= redirect_pc;
            state_q <= DROP;
          end
        end
        DROP: begin
          // Old request still outstanding; later redirects just update pc_q.
          if (flush) begin
            pc_q <= redirect_pc;
          end
          if (iresp.data_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ireq.valid  = (state_q == REQ) || (state_q == DROP);
  assign ireq.addr   = req_addr_q;
  assign dataF.valid = !empty;
  assign dataF.instr = head;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (drop_rsp) begin
        perf_dropped_q <= perf_dropped_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  // Without counters the discard condition has no consumer.
  logic unused_drop;
  assign unused_drop = drop_rsp;
`endif

  // Requests are only issued with room left, so a push can never meet a full queue.
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module  : tb_fetch_ctrl
// Purpose : Directed self-checking bench for fetch_ctrl. It covers sequential
//           fetch, queue back-pressure, redirect during an outstanding request,
//           redirect with a coincident response, a double redirect and reset
//           mid-request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  word_t       redirect_pc;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  fetch_data_t dataF;
  logic        readyD;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC (64'h8000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .redirect_pc  (redirect_pc),
    .ireq         (ireq),
    .iresp        (iresp),
    .dataF        (dataF),
    .readyD       (readyD)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
`endif
  );

  task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ok, input logic [31:0] d, input logic fl, input word_t rpc);
    iresp.data_ok = ok;
    iresp.data    = d;
    flush         = fl;
    redirect_pc   = rpc;
  endtask

  task automatic chk_req(input string tag, input logic v, input word_t a);
    check({tag, ".ireq.valid"}, 96'(ireq.valid), 96'(v));
    if (v) check({tag, ".ireq.addr"}, 96'(ireq.addr), 96'(a));
  endtask

  task automatic chk_q(input string tag, input logic v, input word_t pc, input logic [31:0] d);
    check({tag, ".dataF.valid"}, 96'(dataF.valid), 96'(v));
    if (v) check({tag, ".dataF.instr"}, 96'(dataF.instr), {pc, d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 64'h0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  localparam logic [31:0] D0 = 32'h0000_0013;
  localparam logic [31:0] D1 = 32'h0010_0093;
  localparam logic [31:0] D2 = 32'h0020_0113;
  localparam logic [31:0] DX = 32'hdead_beef;

  initial begin
    readyD = 1'b1;

    // Sequential fetch with decode always ready.
    do_reset();
    check("rst.ireq.valid", 96'(ireq.valid), 96'(0));
    check("rst.ireq.addr", 96'(ireq.addr), 96'(64'h8000_0000));
    check("rst.dataF.valid", 96'(dataF.valid), 96'(0));
    check("rst.dataF.instr", 96'(dataF.instr), 96'(0));
    tick();
    chk_req("seq.a", 1'b1, 64'h8000_0000);
    drive(1'b1, D0, 1'b0, 64'h0); tick();
    chk_q("seq.b", 1'b1, 64'h8000_0000, D0);
    chk_req("seq.b", 1'b1, 64'h8000_0004);
    drive(1'b1, D1, 1'b0, 64'h0); tick();
    chk_q("seq.c", 1'b1, 64'h8000_0004, D1);
    chk_req("seq.c", 1'b1, 64'h8000_0008);
    drive(1'b1, D2, 1'b0, 64'h0); tick();
    chk_q("seq.d", 1'b1, 64'h8000_0008, D2);
    chk_req("seq.d", 1'b1, 64'h8000_000C);
    drive(1'b0, 32'h0, 1'b0, 64'h0); tick();
    chk_q("seq.e", 1'b0, 64'h0, 32'h0);
    chk_req("seq.e", 1'b1, 64'h8000_000C);
`ifdef FETCH_CTRL_PERF_EN
    check("seq.perf_fetched", 96'(perf_fetched), 96'(3));
`endif

    // Back-pressure: decode stalled, queue fills after two pushes.
    readyD = 1'b0;
    do_reset();
    tick();
    chk_req("bp.a", 1'b1, 64'h8000_0000);
    drive(1'b1, D0, 1'b0, 64'h0); tick();
    chk_req("bp.b", 1'b1, 64'h8000_0004);
    drive(1'b1, D1, 1'b0, 64'h0); tick();
    chk_req("bp.c", 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0);
    repeat (8) tick();
    chk_req("bp.idle", 1'b0, 64'h0);
    chk_q("bp.idle", 1'b1, 64'h8000_0000, D0);
    readyD = 1'b1; tick();
    chk_req("bp.resume", 1'b1, 64'h8000_0008);
    chk_q("bp.resume", 1'b1, 64'h8000_0004, D1);
    tick();
    chk_q("bp.drain", 1'b0, 64'h0, 32'h0);

    // Redirect while a request has been waiting three cycles.
    do_reset();
    tick();
    drive(1'b1, D0, 1'b0, 64'h0); tick();
    chk_req("fl.b", 1'b1, 64'h8000_0004);
    drive(1'b0, 32'h0, 1'b0, 64'h0);
    repeat (3) tick();
    drive(1'b0, 32'h0, 1'b1, 64'h8000_1000); tick();
    chk_req("fl.drop", 1'b1, 64'h8000_0004);
    chk_q("fl.drop", 1'b0, 64'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0); tick();
    chk_req("fl.hold", 1'b1, 64'h8000_0004);
    drive(1'b1, DX, 1'b0, 64'h0); tick();
    chk_req("fl.done", 1'b0, 64'h0);
    chk_q("fl.done", 1'b0, 64'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0); tick();
    chk_req("fl.next", 1'b1, 64'h8000_1000);

    // Redirect coincident with data_ok.
    drive(1'b1, DX, 1'b1, 64'h8000_1000); tick();
    chk_req("flok.a", 1'b0, 64'h0);
    chk_q("flok.a", 1'b0, 64'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0); tick();
    chk_req("flok.next", 1'b1, 64'h8000_1000);
    chk_q("flok.next", 1'b0, 64'h0, 32'h0);

    // Two redirects while in DROP; the last one wins.
    do_reset();
    tick();
    drive(1'b0, 32'h0, 1'b1, 64'h8000_1000); tick();
    chk_req("dd.b", 1'b1, 64'h8000_0000);
    drive(1'b0, 32'h0, 1'b1, 64'h8000_2000); tick();
    chk_req("dd.c", 1'b1, 64'h8000_0000);
    drive(1'b1, DX, 1'b0, 64'h0); tick();
    chk_req("dd.d", 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b0, 64'h0); tick();
    chk_req("dd.next", 1'b1, 64'h8000_2000);
`ifdef FETCH_CTRL_PERF_EN
    check("dd.perf_dropped", 96'(perf_dropped), 96'(1));
    check("dd.perf_fetched", 96'(perf_fetched), 96'(0));
`endif

    // Reset asserted mid-request with a queued entry.
    drive(1'b1, D2, 1'b0, 64'h0); tick();
    chk_q("rr.a", 1'b1, 64'h8000_2000, D2);
    chk_req("rr.a", 1'b1, 64'h8000_2004);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 64'h0); tick();
    check("rr.ireq.valid", 96'(ireq.valid), 96'(0));
    check("rr.ireq.addr", 96'(ireq.addr), 96'(64'h8000_0000));
    check("rr.dataF.valid", 96'(dataF.valid), 96'(0));
`ifdef FETCH_CTRL_PERF_EN
    check("rr.perf_dropped", 96'(perf_dropped), 96'(0));
`endif
    reset = 1'b0; tick();
    chk_req("rr.restart", 1'b1, 64'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
